// File: rtl/clause_array_seq_if.sv
// Load and writeback streams between the bin manager and the clause array sequencer.
interface clause_array_seq_if #(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_C_LEN = 4
);
    localparam int IDX_W = (NUM_CLAUSES > 2) ? $clog2(NUM_CLAUSES) : 1;

    logic [NUM_VARS*2-1:0]  ld_clause_i;
    logic [WIDTH_C_LEN-1:0] ld_len_i;
    logic                   ld_valid_i;
    logic                   ld_ready_o;

    logic [NUM_VARS*2-1:0]  wb_clause_o;
    logic [IDX_W-1:0]       wb_index_o;
    logic                   wb_valid_o;
    logic                   wb_ready_i;

    modport master (
        output ld_clause_i, ld_len_i, ld_valid_i, wb_ready_i,
        input  ld_ready_o, wb_clause_o, wb_index_o, wb_valid_o
    );

    modport slave (
        input  ld_clause_i, ld_len_i, ld_valid_i, wb_ready_i,
        output ld_ready_o, wb_clause_o, wb_index_o, wb_valid_o
    );
endinterface

// File: rtl/clause_array_seq.sv
// Clause array sequencer: bin load, writeback and learnt-clause insertion,
// driving one-hot array read/write strobes with fully registered outputs.
module clause_array_seq #(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_C_LEN = 4,
    localparam int IDX_W = (NUM_CLAUSES > 2) ? $clog2(NUM_CLAUSES) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    clause_array_seq_if.slave                  bus,
    input  logic                               start_load_i,
    output logic                               load_done_o,
    input  logic                               start_wb_i,
    output logic                               wb_done_o,
    input  logic                               add_learntc_i,
    input  logic [NUM_VARS*2-1:0]              learntc_i,
    input  logic [WIDTH_C_LEN-1:0]             learntc_len_i,
    output logic                               learntc_done_o,
    output logic [IDX_W-1:0]                   learntc_idx_o,
    input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] lens_i,
    input  logic [NUM_VARS*2-1:0]              arr_clause_i,
    output logic [NUM_CLAUSES-1:0]             arr_wr_o,
    output logic [NUM_CLAUSES-1:0]             arr_rd_o,
    output logic [NUM_VARS*2-1:0]              arr_clause_o,
    output logic [WIDTH_C_LEN-1:0]             arr_len_o,
    output logic                               busy_o
);
    localparam int HALF = NUM_CLAUSES / 2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLAUSES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WB_RD, WB_SEND, INS_SEL, INS_WR} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   ld_ready_q, ld_ready_d;
    logic                   load_done_q, load_done_d;
    logic [NUM_VARS*2-1:0]  wb_clause_q, wb_clause_d;
    logic [IDX_W-1:0]       wb_index_q, wb_index_d;
    logic                   wb_valid_q, wb_valid_d;
    logic                   wb_done_q, wb_done_d;
    logic                   learntc_done_q, learntc_done_d;
    logic [IDX_W-1:0]       learntc_idx_q, learntc_idx_d;
    logic [NUM_CLAUSES-1:0] arr_wr_q, arr_wr_d;
    logic [NUM_CLAUSES-1:0] arr_rd_q, arr_rd_d;
    logic [NUM_VARS*2-1:0]  arr_clause_q, arr_clause_d;
    logic [WIDTH_C_LEN-1:0] arr_len_q, arr_len_d;
    logic                   busy_q, busy_d;

    logic [IDX_W-1:0]       sel, best_sel, empty_sel;
    logic [WIDTH_C_LEN-1:0] best_len, slot_len;
    logic                   found_empty;

    function automatic logic [NUM_CLAUSES-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    assign cnt_inc = cnt_q + 1'b1;

    // Replacement slot: lowest empty learnt slot, else the longest (lowest index on ties).
    always_comb begin
        found_empty = 1'b0;
        empty_sel   = IDX_W'(HALF);
        best_sel    = IDX_W'(HALF);
        best_len    = lens_i[HALF*WIDTH_C_LEN +: WIDTH_C_LEN];
        slot_len    = '0;
        for (int unsigned k = HALF; k < NUM_CLAUSES; k++) begin
            slot_len = lens_i[k*WIDTH_C_LEN +: WIDTH_C_LEN];
            if (!found_empty && slot_len == '0) begin
                found_empty = 1'b1;
                empty_sel   = IDX_W'(k);
            end
            if (slot_len > best_len) begin
                best_len = slot_len;
                best_sel = IDX_W'(k);
            end
        end
        sel = found_empty ? empty_sel : best_sel;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ld_ready_d     = ld_ready_q;
        load_done_d    = 1'b0;
        wb_clause_d    = wb_clause_q;
        wb_index_d     = wb_index_q;
        wb_valid_d     = wb_valid_q;
        wb_done_d      = 1'b0;
        learntc_done_d = 1'b0;
        learntc_idx_d  = learntc_idx_q;
        arr_wr_d       = '0;
        arr_rd_d       = '0;
        arr_clause_d   = arr_clause_q;
        arr_len_d      = arr_len_q;

        unique case (state_q)
            IDLE: begin
                if (start_load_i) begin
                    state_d    = LOAD;
                    cnt_d      = '0;
                    ld_ready_d = 1'b1;
                end else if (start_wb_i) begin
                    state_d  = WB_RD;
                    cnt_d    = '0;
                    arr_rd_d = onehot('0);
                end else if (add_learntc_i) begin
                    state_d = INS_SEL;
                end
            end
            LOAD: begin
                if (bus.ld_valid_i && ld_ready_q) begin
                    arr_wr_d     = onehot(cnt_q);
                    arr_clause_d = bus.ld_clause_i;
                    arr_len_d    = bus.ld_len_i;
                    cnt_d        = cnt_inc;
                    if (cnt_q == LAST) begin
                        ld_ready_d  = 1'b0;
                        load_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            WB_RD: state_d = WB_SEND;
            WB_SEND: begin
                // First WB_SEND cycle is the one where the array read data is valid.
                if (!wb_valid_q) begin
                    wb_clause_d = arr_clause_i;
                    wb_index_d  = cnt_q;
                    wb_valid_d  = 1'b1;
                end else if (bus.wb_ready_i) begin
                    wb_valid_d = 1'b0;
                    if (cnt_q == LAST) begin
                        wb_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d    = cnt_inc;
                        arr_rd_d = onehot(cnt_inc);
                        state_d  = WB_RD;
                    end
                end
            end
            INS_SEL: begin
                arr_wr_d       = onehot(sel);
                arr_clause_d   = learntc_i;
                arr_len_d      = learntc_len_i;
                learntc_done_d = 1'b1;
                learntc_idx_d  = sel;
                state_d        = INS_WR;
            end
            INS_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            ld_ready_q     <= 1'b0;
            load_done_q    <= 1'b0;
            wb_clause_q    <= '0;
            wb_index_q     <= '0;
            wb_valid_q     <= 1'b0;
            wb_done_q      <= 1'b0;
            learntc_done_q <= 1'b0;
            learntc_idx_q  <= '0;
            arr_wr_q       <= '0;
            arr_rd_q       <= '0;
            arr_clause_q   <= '0;
            arr_len_q      <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ld_ready_q     <= ld_ready_d;
            load_done_q    <= load_done_d;
            wb_clause_q    <= wb_clause_d;
            wb_index_q     <= wb_index_d;
            wb_valid_q     <= wb_valid_d;
            wb_done_q      <= wb_done_d;
            learntc_done_q <= learntc_done_d;
            learntc_idx_q  <= learntc_idx_d;
            arr_wr_q       <= arr_wr_d;
            arr_rd_q       <= arr_rd_d;
            arr_clause_q   <= arr_clause_d;
            arr_len_q      <= arr_len_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.ld_ready_o  = ld_ready_q;
    assign bus.wb_clause_o = wb_clause_q;
    assign bus.wb_index_o  = wb_index_q;
    assign bus.wb_valid_o  = wb_valid_q;
    assign load_done_o     = load_done_q;
    assign wb_done_o       = wb_done_q;
    assign learntc_done_o  = learntc_done_q;
    assign learntc_idx_o   = learntc_idx_q;
    assign arr_wr_o        = arr_wr_q;
    assign arr_rd_o        = arr_rd_q;
    assign arr_clause_o    = arr_clause_q;
    assign arr_len_o       = arr_len_q;
    assign busy_o          = busy_q;
endmodule

// File: tb/tb_clause_array_seq.sv
// Bench for clause_array_seq: acts as bin manager, writeback sink and clause array,
// and checks every strobe cycle against a transaction-level expectation queue.
module tb_clause_array_seq;
    localparam int N  = 8;
    localparam int V  = 8;
    localparam int W  = 4;
    localparam int CW = V * 2;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_load = 1'b0, start_wb = 1'b0, add_l = 1'b0;
    logic [CW-1:0] learntc = '0;
    logic [W-1:0]  learntc_len = '0;
    logic          load_done, wb_done, learntc_done, busy;
    logic [IW-1:0] learntc_idx;
    logic [N*W-1:0] lens_i, lens_h, ovr_lens = '0;
    logic          use_ovr = 1'b0;
    logic [CW-1:0] arr_clause_rd = '0;
    logic [N-1:0]  arr_wr, arr_rd;
    logic [CW-1:0] arr_clause_w;
    logic [W-1:0]  arr_len_w;

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit chk_en = 1'b0;

    clause_array_seq_if #(.NUM_CLAUSES(N), .NUM_VARS(V), .WIDTH_C_LEN(W)) bus ();

    clause_array_seq #(.NUM_CLAUSES(N), .NUM_VARS(V), .WIDTH_C_LEN(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .start_load_i(start_load), .load_done_o(load_done),
        .start_wb_i(start_wb), .wb_done_o(wb_done),
        .add_learntc_i(add_l), .learntc_i(learntc), .learntc_len_i(learntc_len),
        .learntc_done_o(learntc_done), .learntc_idx_o(learntc_idx),
        .lens_i(lens_i), .arr_clause_i(arr_clause_rd),
        .arr_wr_o(arr_wr), .arr_rd_o(arr_rd),
        .arr_clause_o(arr_clause_w), .arr_len_o(arr_len_w), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Clause array stand-in: stores strobed writes, returns read data one cycle after the strobe.
    logic [CW-1:0] h_mem [N] = '{default: '0};
    logic [W-1:0]  h_len [N] = '{default: '0};
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (arr_wr[i]) begin
                h_mem[i] <= arr_clause_w;
                h_len[i] <= arr_len_w;
            end
            if (arr_rd[i]) arr_clause_rd <= h_mem[i];
        end
    end
    always_comb begin
        lens_h = '0;
        for (int i = 0; i < N; i++) lens_h[i*W +: W] = h_len[i];
        lens_i = use_ovr ? ovr_lens : lens_h;
    end

    // Reference contents of the array as the transactions should have left it.
    logic [CW-1:0] ref_mem [N];
    logic [W-1:0]  ref_len [N];

    typedef struct {
        int            c;
        logic [N-1:0]  mask;
        logic [CW-1:0] cl;
        logic [W-1:0]  len;
        bit            ld_done;
        bit            ins_done;
        logic [IW-1:0] idx;
    } wexp_t;
    typedef struct {
        int           c;
        logic [N-1:0] mask;
    } rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];
    wexp_t ew;
    rexp_t er;
    int exp_wbdone = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_w(input int c, input int slot, input logic [CW-1:0] cl,
                          input logic [W-1:0] ln, input bit ld, input bit ins);
        wexp_t w;
        w.c = c; w.mask = N'(1) << slot; w.cl = cl; w.len = ln;
        w.ld_done = ld; w.ins_done = ins; w.idx = IW'(slot);
        wq.push_back(w);
    endtask

    task automatic push_r(input int c, input int slot);
        rexp_t r;
        r.c = c; r.mask = N'(1) << slot;
        rq.push_back(r);
    endtask

    // Strobes and done pulses must appear exactly where the queues say, and nowhere else.
    always @(negedge clk) begin
        if (chk_en) begin
            if (wq.size() > 0 && wq[0].c == cyc) begin
                ew = wq.pop_front();
                chk("arr_wr", arr_wr, ew.mask);
                chk("arr_clause", arr_clause_w, ew.cl);
                chk("arr_len", arr_len_w, ew.len);
                chk("load_done", load_done, ew.ld_done);
                chk("learntc_done", learntc_done, ew.ins_done);
                if (ew.ins_done) chk("learntc_idx", learntc_idx, ew.idx);
            end else begin
                chk("arr_wr_quiet", arr_wr, 0);
                chk("load_done_quiet", load_done, 0);
                chk("learntc_done_quiet", learntc_done, 0);
            end
            if (rq.size() > 0 && rq[0].c == cyc) begin
                er = rq.pop_front();
                chk("arr_rd", arr_rd, er.mask);
            end else begin
                chk("arr_rd_quiet", arr_rd, 0);
            end
            chk("wb_done", wb_done, (cyc == exp_wbdone));
        end
    end

    function automatic int pick(input logic [N*W-1:0] v);
        int mx = 0;
        for (int k = N/2; k < N; k++) if (v[k*W +: W] == '0) return k;
        for (int k = N/2; k < N; k++) if (int'(v[k*W +: W]) > mx) mx = int'(v[k*W +: W]);
        for (int k = N/2; k < N; k++) if (int'(v[k*W +: W]) == mx) return k;
        return N/2;
    endfunction

    function automatic logic [N*W-1:0] ref_lens();
        logic [N*W-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = ref_len[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        start_load = 0; start_wb = 0; add_l = 0;
        bus.ld_valid_i = 0; bus.wb_ready_i = 0;
        tick();
        tick();
        rst = 1'b0;
        wq.delete(); rq.delete(); exp_wbdone = -1;
        chk("rst_arr_wr", arr_wr, 0);
        chk("rst_arr_rd", arr_rd, 0);
        chk("rst_ld_ready", bus.ld_ready_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wb_valid", bus.wb_valid_o, 0);
        chk("rst_wb_clause", bus.wb_clause_o, 0);
        chk("rst_arr_clause", arr_clause_w, 0);
        chk("rst_learntc_idx", learntc_idx, 0);
        chk_en = 1'b1;
    endtask

    // mode 0: ld_valid alternates starting high; mode 1: random valid.
    // abort_at > 0: assert reset in the cycle after that many handshakes.
    task automatic load_bin(input int mode, input bit add_same, input int abort_at);
        int k = 0;
        int c0;
        logic [CW-1:0] cl;
        logic [W-1:0] ln;
        bit v;
        chk("ld_ready_idle", bus.ld_ready_o, 0);
        start_load = 1; add_l = add_same; learntc = CW'($urandom); learntc_len = W'($urandom);
        tick();
        start_load = 0; add_l = 0;
        c0 = cyc;
        for (int it = 0; it < 200 && k < N; it++) begin
            chk("ld_ready", bus.ld_ready_o, 1);
            chk("busy_load", busy, 1);
            v = (mode == 0) ? ((cyc - c0) % 2 == 0) : ($urandom_range(0, 9) < 6);
            cl = CW'($urandom); ln = W'($urandom);
            bus.ld_valid_i = v; bus.ld_clause_i = cl; bus.ld_len_i = ln;
            add_l = ($urandom_range(0, 3) == 0);
            start_wb = ($urandom_range(0, 5) == 0);
            if (v) begin
                push_w(cyc + 1, k, cl, ln, (k == N - 1), 0);
                ref_mem[k] = cl; ref_len[k] = ln;
                k++;
            end
            if (abort_at > 0 && v && k == abort_at) begin
                tick();
                bus.ld_valid_i = 0; add_l = 0; start_wb = 0; rst = 1;
                tick();
                rst = 0;
                chk("abort_arr_wr", arr_wr, 0);
                chk("abort_busy", busy, 0);
                chk("abort_ld_ready", bus.ld_ready_o, 0);
                return;
            end
            tick();
        end
        bus.ld_valid_i = 0; add_l = 0; start_wb = 0;
        if (k < N) chk("load_progress", k, N);
        chk("ld_ready_end", bus.ld_ready_o, 0);
        chk("busy_load_end", busy, 0);
    endtask

    task automatic wb_all(input int stall_slot, input int stall_n, input bit rnd, input bit add_same);
        int r;
        int stalls;
        start_wb = 1; add_l = add_same;
        tick();
        start_wb = 0; add_l = 0;
        r = cyc;
        for (int i = 0; i < N; i++) begin
            push_r(r, i);
            chk("wb_valid_rd", bus.wb_valid_o, 0);
            chk("busy_wb", busy, 1);
            tick();
            chk("wb_valid_lat", bus.wb_valid_o, 0);
            tick();
            stalls = (i == stall_slot) ? stall_n : (rnd ? $urandom_range(0, 2) : 0);
            for (int s = 0; s <= stalls; s++) begin
                chk("wb_valid", bus.wb_valid_o, 1);
                chk("wb_clause", bus.wb_clause_o, ref_mem[i]);
                chk("wb_index", bus.wb_index_o, i);
                add_l = rnd && ($urandom_range(0, 3) == 0);
                bus.wb_ready_i = (s == stalls);
                tick();
            end
            bus.wb_ready_i = 0; add_l = 0;
            chk("wb_valid_drop", bus.wb_valid_o, 0);
            if (i == N - 1) begin
                exp_wbdone = cyc;
                chk("busy_wb_end", busy, 0);
            end else begin
                r = cyc;
            end
        end
        tick();
    endtask

    // exp_idx < 0: expected slot comes from the reference model.
    task automatic insert(input bit ovr, input logic [N*W-1:0] ov, input int exp_idx);
        int sel;
        logic [CW-1:0] cl;
        logic [W-1:0] ln;
        cl = CW'($urandom); ln = W'($urandom);
        use_ovr = ovr; ovr_lens = ov;
        learntc = cl; learntc_len = ln; add_l = 1;
        sel = (exp_idx >= 0) ? exp_idx : pick(ovr ? ov : ref_lens());
        push_w(cyc + 2, sel, cl, ln, 0, 1);
        tick();
        add_l = 0;
        chk("busy_ins_sel", busy, 1);
        tick();
        chk("busy_ins_wr", busy, 1);
        tick();
        chk("busy_ins_end", busy, 0);
        use_ovr = 0;
        ref_mem[sel] = cl; ref_len[sel] = ln;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] rl;
        bus.ld_valid_i = 0; bus.ld_clause_i = '0; bus.ld_len_i = '0; bus.wb_ready_i = 0;
        for (int k = 0; k < N; k++) begin
            ref_mem[k] = '0; ref_len[k] = '0;
        end
        do_reset();

        load_bin(0, 0, 3);
        load_bin(0, 0, 0);
        wb_all(2, 3, 0, 0);

        insert(1, {4'd2, 4'd7, 4'd7, 4'd3, 4'd9, 4'd9, 4'd9, 4'd9}, 5);
        insert(1, {4'd0, 4'd7, 4'd0, 4'd3, 4'd9, 4'd9, 4'd9, 4'd9}, 5);
        insert(1, {4'd1, 4'd1, 4'd1, 4'd1, 4'hF, 4'hF, 4'hF, 4'hF}, 4);
        insert(1, {4'd9, 4'd1, 4'd1, 4'd1, 4'h0, 4'hF, 4'h0, 4'hF}, 7);
        insert(1, {4'd0, 4'd0, 4'd0, 4'd0, 4'h3, 4'h3, 4'h3, 4'h3}, 4);

        load_bin(1, 1, 0);
        wb_all(-1, 0, 0, 1);

        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 3))
                0: load_bin(1, 0, 0);
                1: wb_all(-1, 0, 1, 0);
                2: insert(0, '0, -1);
                default: begin
                    rl = '0;
                    for (int k = 0; k < N; k++)
                        rl[k*W +: W] = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
                    insert(1, rl, -1);
                end
            endcase
            if ($urandom_range(0, 1) == 1) tick();
        end
        wb_all(-1, 0, 1, 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
